// File: rtl/result_serializer.sv
// result_serializer
//   Takes the packed per-slot owner bus produced by Array_selector, snapshots it
//   on start, and streams one {slot, owner} pair per valid/ready transfer.
//   While streaming it builds a per-owner histogram of how many slots each
//   owner holds. After the last pair has been accepted it pulses done once,
//   then returns to idle.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start        capture results and begin a scan (only honoured when idle)
//   results      packed owners, slot i owner = results[i*BIT +: BIT]
//   out_ready    consumer accepts the current pair
//   out_valid    out_slot/out_owner carry a valid pair
//   out_slot     slot index of the current pair
//   out_owner    owner index of the current pair
//   busy         high while scanning and during the done cycle
//   done         one-cycle pulse after the last transfer
//   owner_count  packed histogram, owner j = owner_count[j*CW +: CW]
module result_serializer #(
  parameter int SIZE = 16,
  parameter int K    = 4,
  localparam int BIT = $clog2(K),
  localparam int SW  = $clog2(SIZE),
  localparam int CW  = $clog2(SIZE) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE*BIT-1:0] results,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [SW-1:0]     out_slot,
  output logic [BIT-1:0]    out_owner,
  output logic              busy,
  output logic              done,
  output logic [K*CW-1:0]   owner_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SW-1:0]  ptr_q;
  logic [BIT-1:0] owner_q;
  logic [BIT-1:0] snap_q  [SIZE];
  logic [BIT-1:0] resArr  [SIZE];
  logic [CW-1:0]  cnt_q   [K];

  logic transfer;
  logic lastSlot;

  // Unpack the incoming owner bus so slots can be indexed directly by the
  // slot pointer without width-juggling part selects.
  for (genvar gi = 0; gi < SIZE; gi++) begin : g_unpack
    assign resArr[gi] = results[gi*BIT +: BIT];
  end

  // Repack the histogram counters onto the flat output bus.
  for (genvar gj = 0; gj < K; gj++) begin : g_pack
    assign owner_count[gj*CW +: CW] = cnt_q[gj];
  end

  assign transfer = (state_q == RUN) && out_ready;
  assign lastSlot = (ptr_q == SW'(SIZE - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. DONE is a single-cycle state, and start is only
  // looked at from IDLE so a mid-scan start cannot restart the stream.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (transfer && lastSlot) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: snapshot, slot pointer, presented owner and histogram.
  // owner_q is loaded one step ahead so out_owner comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      owner_q <= '0;
      for (int i = 0; i < SIZE; i++) snap_q[i] <= '0;
      for (int j = 0; j < K; j++) cnt_q[j] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            snap_q  <= resArr;
            ptr_q   <= '0;
            owner_q <= resArr[0];
            for (int j = 0; j < K; j++) cnt_q[j] <= '0;
          end
        end
        RUN: begin
          if (out_ready) begin
            cnt_q[owner_q] <= cnt_q[owner_q] + CW'(1);
            if (!lastSlot) begin
              ptr_q   <= ptr_q + SW'(1);
              owner_q <= snap_q[ptr_q + SW'(1)];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Slot/owner are forced to zero whenever no pair is being presented so
  // the outputs read as all-zero outside a scan.
  assign out_valid = (state_q == RUN);
  assign out_slot  = out_valid ? ptr_q : '0;
  assign out_owner = out_valid ? owner_q : '0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_result_serializer.sv
// tb_result_serializer
//   Scoreboard bench for result_serializer. The stimulus side pushes the
//   expected {slot, owner} sequence and per-owner counts for every scan; a
//   separate monitor pops and compares on each accepted transfer, checks that
//   stalled pairs stay put, and checks the done pulse position. A second
//   instance with SIZE=8, K=2 covers the parameter sweep.
module tb_result_serializer;

  localparam int SIZE  = 16;
  localparam int K     = 4;
  localparam int BIT   = 2;
  localparam int SW    = 4;
  localparam int CW    = 5;
  localparam int SIZE2 = 8;
  localparam int K2    = 2;
  localparam int BIT2  = 1;
  localparam int SW2   = 3;
  localparam int CW2   = 4;

  typedef struct {
    int slot;
    int owner;
  } pair_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 start;
  logic [SIZE*BIT-1:0]  results;
  logic                 out_ready;
  logic                 out_valid;
  logic [SW-1:0]        out_slot;
  logic [BIT-1:0]       out_owner;
  logic                 busy;
  logic                 done;
  logic [K*CW-1:0]      owner_count;

  logic                 start2;
  logic [SIZE2*BIT2-1:0] results2;
  logic                 ready2;
  logic                 out_valid2;
  logic [SW2-1:0]       out_slot2;
  logic [BIT2-1:0]      out_owner2;
  logic                 busy2;
  logic                 done2;
  logic [K2*CW2-1:0]    owner_count2;

  result_serializer #(.SIZE(SIZE), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .results(results),
    .out_ready(out_ready), .out_valid(out_valid), .out_slot(out_slot),
    .out_owner(out_owner), .busy(busy), .done(done), .owner_count(owner_count)
  );

  result_serializer #(.SIZE(SIZE2), .K(K2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .results(results2),
    .out_ready(ready2), .out_valid(out_valid2), .out_slot(out_slot2),
    .out_owner(out_owner2), .busy(busy2), .done(done2), .owner_count(owner_count2)
  );

  int    checkCount = 0;
  int    failCount  = 0;
  pair_t expQ[$];
  int    refCount[K];
  int    readyMode = 0;
  logic  expectDone = 1'b0;
  logic  holdPending = 1'b0;
  logic [SW-1:0]  heldSlot;
  logic [BIT-1:0] heldOwner;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string msg);
    checkCount++;
    failCount++;
    $display("[TB] FAIL %s", msg);
  endtask

  // Monitor: compares every accepted pair against the scoreboard, checks
  // that stalled pairs are held, and that done follows the last slot.
  always @(negedge clk) begin
    pair_t e;
    if (holdPending) begin
      checkOutput("stall valid", out_valid, 1);
      checkOutput("stall slot", out_slot, heldSlot);
      checkOutput("stall owner", out_owner, heldOwner);
      holdPending = 1'b0;
    end
    if (expectDone) begin
      checkOutput("done after last", done, 1);
      checkOutput("valid during done", out_valid, 0);
      expectDone = 1'b0;
    end else if (done === 1'b1) begin
      reportFail("unexpected done pulse");
    end
    if (out_valid === 1'b1 && rst === 1'b0) begin
      if (out_ready === 1'b1) begin
        if (expQ.size() == 0) begin
          reportFail($sformatf("pair slot=%0d with empty scoreboard", out_slot));
        end else begin
          e = expQ.pop_front();
          checkOutput("pair slot", out_slot, e.slot);
          checkOutput($sformatf("pair owner slot %0d", e.slot), out_owner, e.owner);
          if (e.slot == SIZE - 1) expectDone = 1'b1;
        end
      end else begin
        holdPending = 1'b1;
        heldSlot    = out_slot;
        heldOwner   = out_owner;
      end
    end
  end

  // Consumer ready pattern: 0 = always ready, 1 = alternate, 2 = random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Issue a start and load the reference: slot i belongs to owner
  // (res >> BIT*i) mod K, and each owner's count is how often it appears.
  task automatic applyStimulus(input logic [SIZE*BIT-1:0] res);
    pair_t p;
    @(posedge clk);
    #1;
    results = res;
    start   = 1'b1;
    for (int j = 0; j < K; j++) refCount[j] = 0;
    for (int i = 0; i < SIZE; i++) begin
      p.slot  = i;
      p.owner = int'((longint'(res) >> (BIT * i)) % K);
      expQ.push_back(p);
      refCount[p.owner]++;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cycles = n;
        return;
      end
    end
    reportFail("timeout waiting for done");
  endtask

  task automatic checkCounts(input string tag);
    int sum;
    sum = 0;
    for (int j = 0; j < K; j++) begin
      checkOutput($sformatf("%s owner_count[%0d]", tag, j), owner_count[j*CW +: CW], refCount[j]);
      sum += int'(owner_count[j*CW +: CW]);
    end
    checkOutput($sformatf("%s count sum", tag), sum, SIZE);
    checkOutput($sformatf("%s scoreboard drained", tag), expQ.size(), 0);
  endtask

  initial begin
    int cyc;
    int n;
    int ones;
    logic [SIZE*BIT-1:0] pat;

    rst       = 1'b1;
    start     = 1'b1;
    results   = $urandom;
    out_ready = 1'b1;
    start2    = 1'b0;
    results2  = '0;
    ready2    = 1'b1;

    // Reset held for two cycles while start is asserted.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset owner_count", owner_count, 0);
    checkOutput("reset out_slot", out_slot, 0);
    checkOutput("reset out_owner", out_owner, 0);
    checkOutput("reset busy2", busy2, 0);
    rst   = 1'b0;
    start = 1'b0;

    // Full scan, owner i%4, consumer always ready.
    $display("[TB] full scan");
    readyMode = 0;
    for (int i = 0; i < SIZE; i++) pat[i*BIT +: BIT] = BIT'(i % K);
    applyStimulus(pat);
    waitDone(cyc);
    checkOutput("full scan cycles", cyc, SIZE + 1);
    checkOutput("busy during done", busy, 1);
    checkCounts("full");

    // Backpressure on alternate cycles, every slot owned by owner 2.
    $display("[TB] backpressure");
    readyMode = 1;
    applyStimulus({SIZE{2'd2}});
    waitDone(cyc);
    checkCounts("stall");

    // Change results and pulse start mid-scan; the capture must be kept.
    $display("[TB] snapshot / start ignore");
    readyMode = 0;
    pat = $urandom;
    applyStimulus(pat);
    repeat (2) @(posedge clk);
    #1;
    results = ~pat;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(cyc);
    checkCounts("snapshot");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("no restart busy", busy, 0);
    checkOutput("no restart valid", out_valid, 0);

    // Random scans with random consumer readiness.
    $display("[TB] random scans");
    readyMode = 2;
    for (int r = 0; r < 3; r++) begin
      applyStimulus($urandom);
      waitDone(cyc);
      checkCounts($sformatf("random%0d", r));
    end

    // Reset while slot 7 is presented, then rescan from slot 0.
    $display("[TB] mid-scan reset");
    readyMode = 0;
    applyStimulus($urandom);
    n = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1 && out_slot == SW'(7)) begin
        n = 1;
        break;
      end
    end
    if (n == 0) reportFail("slot 7 never presented");
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset out_valid", out_valid, 0);
    checkOutput("midreset busy", busy, 0);
    checkOutput("midreset done", done, 0);
    checkOutput("midreset owner_count", owner_count, 0);
    rst = 1'b0;
    expQ.delete();
    holdPending = 1'b0;
    repeat (4) @(posedge clk);
    applyStimulus($urandom);
    waitDone(cyc);
    checkOutput("rescan cycles", cyc, SIZE + 1);
    checkCounts("rescan");

    // SIZE=8, K=2 instance with random owners; counts are a popcount.
    $display("[TB] SIZE=8 K=2 sweep");
    for (int r = 0; r < 2; r++) begin
      @(posedge clk);
      #1;
      results2 = SIZE2'($urandom);
      start2   = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      n = 0;
      cyc = 0;
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        if (out_valid2 === 1'b1) begin
          checkOutput("sweep slot", out_slot2, n);
          checkOutput($sformatf("sweep owner slot %0d", n), out_owner2, (results2 >> n) & 1);
          n++;
        end
        if (done2 === 1'b1) begin
          cyc = 1;
          break;
        end
      end
      if (cyc == 0) reportFail("sweep timeout waiting for done2");
      ones = $countones(results2);
      checkOutput("sweep transfers", n, SIZE2);
      checkOutput("sweep busy2 in done", busy2, 1);
      checkOutput("sweep owner1 count", owner_count2[CW2 +: CW2], ones);
      checkOutput("sweep owner0 count", owner_count2[0 +: CW2], SIZE2 - ones);
      checkOutput("sweep sum", int'(owner_count2[0 +: CW2]) + int'(owner_count2[CW2 +: CW2]), SIZE2);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
